// File: rtl/activation_stream_fp16.sv
// activation_stream_fp16: multi-lane FP16 activation (bypass / ReLU / leaky / clip)
// behind a 2-stage valid/ready pipeline, with frame tracking and a per-frame
// count of zero-valued outputs.

// Per-lane activation, purely combinational. Works on raw binary16 fields.
module act_lane #(
  parameter int LEAK_SHIFT = 3
) (
  input  logic [15:0] x_i,
  input  logic [1:0]  mode_i,
  input  logic [15:0] clip_i,
  output logic [15:0] y_o
);
  logic       sgn;
  logic [4:0] expo;
  logic [9:0] mant;
  logic       is_nan;

  // Activation select; NaN always passes, -Inf stays -Inf under leaky scaling
  always_comb begin
    sgn    = x_i[15];
    expo   = x_i[14:10];
    mant   = x_i[9:0];
    is_nan = (expo == 5'h1f) && (mant != 10'd0);
    y_o    = x_i;
    if (!is_nan) begin
      unique case (mode_i)
        2'b00: y_o = x_i;
        2'b01: if (sgn) y_o = 16'h0000;
        2'b10: begin
          // Scaling by 2^-LEAK_SHIFT is an exponent subtract; results that
          // would go denormal flush to +0 rather than being shifted.
          if (sgn && expo != 5'h1f) begin
            if (expo > 5'(LEAK_SHIFT)) y_o = {1'b1, expo - 5'(LEAK_SHIFT), mant};
            else                       y_o = 16'h0000;
          end
        end
        2'b11: begin
          if (sgn)                          y_o = 16'h0000;
          else if (x_i[14:0] > clip_i[14:0]) y_o = clip_i;
        end
      endcase
    end
  end
endmodule

module activation_stream_fp16 #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int H          = 10,
  parameter int W          = 10,
  parameter int CHANNELS   = 16,
  parameter int LEAK_SHIFT = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [1:0]                         mode,
  input  logic [15:0]                        clip_val,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]        in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [LANES*DATA_WIDTH-1:0]        out_data,
  output logic                               out_last,
  output logic [$clog2(H*W*CHANNELS+1)-1:0]  zero_count,
  output logic                               stat_valid
);
  localparam int FRAME_BEATS = H*W*CHANNELS/LANES;
  localparam int CW  = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam int BZW = $clog2(LANES+1);
  localparam int ZW  = $clog2(H*W*CHANNELS+1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(FRAME_BEATS-1);

  // Handshake
  logic s1_valid_q, s2_valid_q;
  logic s1_adv, s2_adv, in_fire, out_fire;

  // Frame tracking and latched per-frame controls
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic [1:0]    mode_q, mode_d;
  logic [15:0]   clip_q, clip_d;
  logic          frame_start, beat_last;
  logic [1:0]    cur_mode;
  logic [15:0]   cur_clip;

  // Pipeline payload
  logic [LANES-1:0][DATA_WIDTH-1:0] s1_data_q, act_y, s2_data_q;
  logic [1:0]    s1_mode_q;
  logic [15:0]   s1_clip_q;
  logic          s1_last_q, s2_last_q;
  logic [BZW-1:0] beat_zeros, s2_zeros_q;

  // Statistics
  logic [ZW-1:0] zero_acc_q, zero_acc_d, zero_count_q, zero_count_d;
  logic          stat_valid_q, stat_valid_d;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  assign in_fire  = in_valid && s1_adv;
  assign out_fire = s2_valid_q && out_ready;

  assign out_valid  = s2_valid_q;
  assign out_data   = s2_data_q;
  assign out_last   = s2_last_q;
  assign zero_count = zero_count_q;
  assign stat_valid = stat_valid_q;

  // Frame start uses the live controls so beat 0 already sees the new mode
  always_comb begin
    frame_start = (beat_cnt_q == '0);
    beat_last   = (beat_cnt_q == LAST_BEAT);
    cur_mode    = frame_start ? mode     : mode_q;
    cur_clip    = frame_start ? clip_val : clip_q;
    beat_cnt_d  = beat_cnt_q;
    mode_d      = mode_q;
    clip_d      = clip_q;
    if (in_fire) begin
      beat_cnt_d = beat_last ? '0 : beat_cnt_q + CW'(1);
      if (frame_start) begin
        mode_d = mode;
        clip_d = clip_val;
      end
    end
  end

  // Frame counter and latched controls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q <= '0;
      mode_q     <= 2'b01;
      clip_q     <= 16'h4600;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      mode_q     <= mode_d;
      clip_q     <= clip_d;
    end
  end

  // Stage 1: capture raw lanes with the controls that apply to this beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= 2'b01;
      s1_clip_q  <= 16'h4600;
      s1_last_q  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_data_q <= in_data;
        s1_mode_q <= cur_mode;
        s1_clip_q <= cur_clip;
        s1_last_q <= beat_last;
      end
    end
  end

  // One activation unit per lane
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    act_lane #(.LEAK_SHIFT(LEAK_SHIFT)) u_lane (
      .x_i    (s1_data_q[i]),
      .mode_i (s1_mode_q),
      .clip_i (s1_clip_q),
      .y_o    (act_y[i])
    );
  end

  // Count lanes whose result is +/-0 in this beat
  always_comb begin
    beat_zeros = '0;
    for (int i = 0; i < LANES; i++)
      beat_zeros = beat_zeros + BZW'(act_y[i][14:0] == 15'd0);
  end

  // Stage 2: output register; holds while downstream stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_last_q  <= 1'b0;
      s2_zeros_q <= '0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q  <= act_y;
        s2_last_q  <= s1_last_q;
        s2_zeros_q <= beat_zeros;
      end
    end
  end

  // Zero accounting closes on the accepted last beat of each frame
  always_comb begin
    zero_acc_d   = zero_acc_q;
    zero_count_d = zero_count_q;
    stat_valid_d = 1'b0;
    if (out_fire) begin
      if (s2_last_q) begin
        zero_count_d = zero_acc_q + ZW'(s2_zeros_q);
        zero_acc_d   = '0;
        stat_valid_d = 1'b1;
      end else begin
        zero_acc_d = zero_acc_q + ZW'(s2_zeros_q);
      end
    end
  end

  // Statistics registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_acc_q   <= '0;
      zero_count_q <= '0;
      stat_valid_q <= 1'b0;
    end else begin
      zero_acc_q   <= zero_acc_d;
      zero_count_q <= zero_count_d;
      stat_valid_q <= stat_valid_d;
    end
  end
endmodule
